// File: rtl/sipmroc_pkg.sv
// sipmroc_pkg: shared sizes, frame width helper and readout FSM states
package sipmroc_pkg;
  localparam int N_CH = 17;
  localparam int ID_W = 5;
  localparam int DATA_W = 12;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;
  function automatic int frame_w(input int data_w);
    return ID_W + data_w + 1;
  endfunction
endpackage

// File: rtl/sipmroc_rr_arbiter.sv
// sipmroc_rr_arbiter: combinational round-robin finder (rotate, pick lowest, rotate back)
//   req       : per-channel requests
//   ptr       : highest-priority channel this round (always < N_CH)
//   gnt_idx   : first requester at or after ptr, wrapping
//   gnt_valid : any request present
module sipmroc_rr_arbiter #(
  parameter int N_CH = sipmroc_pkg::N_CH
) (
  input  logic [N_CH-1:0]              req,
  input  logic [sipmroc_pkg::ID_W-1:0] ptr,
  output logic [sipmroc_pkg::ID_W-1:0] gnt_idx,
  output logic                         gnt_valid
);
  import sipmroc_pkg::*;
  localparam int IW = ID_W + 1;
  logic [2*N_CH-1:0] dbl;
  logic [IW-1:0] off, sum;
  assign dbl = {req, req} >> ptr;
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) off = dbl[i] ? IW'(i) : off;
  end
  assign sum = off + {1'b0, ptr};
  assign gnt_idx = (sum >= IW'(N_CH)) ? ID_W'(sum - IW'(N_CH)) : ID_W'(sum);
  assign gnt_valid = |req;
endmodule

// File: rtl/sipmroc_readout_arbiter.sv
// sipmroc_readout_arbiter: round-robin channel readout into parity-protected serial frames
//   clk_200m / rst        : clock, synchronous active-high reset
//   ch_req / ch_data      : per-channel request and held measurement word
//   ch_ack                : one-cycle capture pulse for the granted channel
//   busy                  : FSM not idle
//   serial_data_en / data : frame bits MSB first, data forced 0 when not enabled
module sipmroc_readout_arbiter #(
  parameter int N_CH = sipmroc_pkg::N_CH,
  parameter int DATA_W = sipmroc_pkg::DATA_W,
  parameter int BIT_DIV = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk_200m,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_ack,
  output logic                     busy,
  output logic                     serial_data_en,
  output logic                     serial_data
);
  import sipmroc_pkg::*;
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int DW = $clog2(BIT_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  state_e state_q, state_d;
  logic [ID_W-1:0] g_q, g_d, rr_q, rr_d, gnt_idx;
  logic gnt_valid;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DATA_W-1:0] word;
  sipmroc_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req(ch_req),
    .ptr(rr_q),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );
  assign word = ch_data[g_q*DATA_W +: DATA_W];
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    rr_d = rr_q;
    sh_d = sh_q;
    bit_d = bit_q;
    div_d = div_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        g_d = gnt_idx;
        state_d = LOAD;
      end
      LOAD: begin
        sh_d = {g_q, word, ^{g_q, word}};
        rr_d = (g_q == ID_W'(N_CH - 1)) ? '0 : g_q + ID_W'(1);
        bit_d = '0;
        div_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (div_q == DW'(BIT_DIV - 1)) begin
        div_d = '0;
        sh_d = sh_q << 1;
        bit_d = bit_q + BW'(1);
        gap_d = '0;
        state_d = (bit_q != BW'(FRAME_W - 1)) ? SHIFT : (GAP_CYCLES == 0) ? IDLE : GAP;
      end else begin
        div_d = div_q + DW'(1);
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        state_d = (gap_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_200m) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      rr_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      rr_q <= rr_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      div_q <= div_d;
      gap_q <= gap_d;
    end
  end
  assign ch_ack = (state_q == LOAD) ? N_CH'(1) << g_q : '0;
  assign busy = state_q != IDLE;
  assign serial_data_en = state_q == SHIFT;
  assign serial_data = serial_data_en & sh_q[FRAME_W-1];
endmodule

// File: tb/tb_sipmroc_readout_arbiter.sv
// tb_sipmroc_readout_arbiter: table-driven, hand-sequenced and random checks against a timeline model
module tb_sipmroc_readout_arbiter;
  localparam int N = 17;
  localparam int FW = 18;
  localparam int PER = 2 + FW + 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] ch_req;
  logic [N*12-1:0] ch_data;
  logic [N-1:0] ack0, ack1;
  logic busy0, busy1, en0, en1, bit0, bit1;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  logic [N-1:0] s_ack0, s_ack1;
  logic s_busy0, s_busy1, s_en0, s_en1, s_bit0, s_bit1;
  typedef struct {
    int dsel;
    int ch;
    logic [11:0] data;
    bit chg;
    logic [17:0] frame;
  } vec_t;
  vec_t tbl[7];
  vec_t rec5;

  always #5 clk = ~clk;

  sipmroc_readout_arbiter dut0 (
    .clk_200m(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data),
    .ch_ack(ack0), .busy(busy0), .serial_data_en(en0), .serial_data(bit0)
  );
  sipmroc_readout_arbiter #(.BIT_DIV(4)) dut1 (
    .clk_200m(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data),
    .ch_ack(ack1), .busy(busy1), .serial_data_en(en1), .serial_data(bit1)
  );

  // Timeline model of dut0: k counts cycles since the request was sampled (0 = idle).
  int k = 0;
  int mptr = 0;
  int mg = 0;
  logic [17:0] mframe = '0;
  logic [N-1:0] m_ack;
  logic m_busy, m_en, m_bit;

  function automatic int search(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
      mptr <= 0;
    end else if (k == 0) begin
      if (|ch_req) begin
        mg <= search(ch_req, mptr);
        mptr <= (search(ch_req, mptr) + 1) % N;
        k <= 1;
      end
    end else if (k == 1) begin
      mframe <= {5'(mg), ch_data[mg*12 +: 12], 1'($countones({5'(mg), ch_data[mg*12 +: 12]}) % 2)};
      k <= 2;
    end else begin
      k <= (k + 1 == PER) ? 0 : k + 1;
    end
  end
  assign m_ack = (k == 1) ? N'(1) << mg : '0;
  assign m_busy = k != 0;
  assign m_en = k >= 2 && k < 2 + FW;
  assign m_bit = m_en ? mframe[FW - 1 - (k - 2)] : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycle);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_ack0 = ack0; s_busy0 = busy0; s_en0 = en0; s_bit0 = bit0;
    s_ack1 = ack1; s_busy1 = busy1; s_en1 = en1; s_bit1 = bit1;
    chk("mdl_ack", 32'(s_ack0), 32'(m_ack));
    chk("mdl_busy", 32'(s_busy0), 32'(m_busy));
    chk("mdl_en", 32'(s_en0), 32'(m_en));
    chk("mdl_bit", 32'(s_bit0), 32'(m_bit));
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic int first_set(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    ch_req = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(s_busy0), 0);
    chk("rst_en", 32'(s_en0), 0);
    chk("rst_ack", 32'(s_ack0), 0);
    chk("rst_busy1", 32'(s_busy1), 0);
    rst = 1'b0;
  endtask

  // Request already driven; cycle 0 is the sampling cycle.
  task automatic collect(input vec_t v);
    int bd, ack_cyc, ack_n, en_first, en_cnt, idle_cyc, herr;
    logic [N-1:0] a, ack_vec;
    logic b, e, bz;
    logic [0:71] bits;
    logic [17:0] fr;
    bd = v.dsel ? 4 : 1;
    ack_cyc = -1; ack_n = 0; en_first = -1; en_cnt = 0; idle_cyc = -1; herr = 0;
    ack_vec = '0; bits = '0; fr = '0;
    for (int cyc = 0; cyc < 150 && idle_cyc < 0; cyc++) begin
      step();
      a = v.dsel ? s_ack1 : s_ack0;
      e = v.dsel ? s_en1 : s_en0;
      b = v.dsel ? s_bit1 : s_bit0;
      bz = v.dsel ? s_busy1 : s_busy0;
      if (cyc == 0) begin
        chk("start_busy", 32'(bz), 0);
        chk("start_en", 32'(e), 0);
      end
      if (a != 0) begin
        ack_n++;
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          ack_vec = a;
        end
        ch_req[v.ch] = 1'b0;
        if (v.chg) ch_data[v.ch*12 +: 12] = 12'h555;
      end
      if (e) begin
        if (en_first < 0) en_first = cyc;
        if (en_cnt < 72) bits[en_cnt] = b;
        en_cnt++;
      end
      if (cyc > 0 && !bz) idle_cyc = cyc;
    end
    chk("ack_vec", 32'(ack_vec), 32'(N'(1) << v.ch));
    chk("ack_cyc", ack_cyc, 1);
    chk("ack_n", ack_n, 1);
    chk("en_first", en_first, 2);
    chk("en_len", en_cnt, FW * bd);
    chk("idle_cyc", idle_cyc, 4 + FW * bd);
    for (int j = 0; j < FW; j++) fr[FW - 1 - j] = bits[j * bd];
    chk("frame", 32'(fr), 32'(v.frame));
    for (int j = 0; j < FW * bd; j++) if (bits[j] !== v.frame[FW - 1 - j / bd]) herr++;
    chk("bit_hold", herr, 0);
  endtask

  task automatic run_single(input vec_t v);
    int w;
    ch_req = '0;
    w = 0;
    do begin
      step();
      w++;
    end while ((s_busy0 || s_busy1) && w < 300);
    chk("idle_wait", 32'(s_busy0 | s_busy1), 0);
    ch_req[v.ch] = 1'b1;
    ch_data[v.ch*12 +: 12] = v.data;
    collect(v);
  endtask

  task automatic run_rr(input string nm, input logic [N-1:0] r, input int cnt);
    int idx[$];
    int t[$];
    do_reset();
    for (int i = 0; i < N; i++) ch_data[i*12 +: 12] = 12'(i * 37 + 5);
    ch_req = r;
    for (int cyc = 0; cyc < 600 && idx.size() < cnt; cyc++) begin
      step();
      if (s_ack0 != 0) begin
        idx.push_back(first_set(s_ack0));
        t.push_back(cyc);
      end
    end
    chk({nm, "_cnt"}, idx.size(), cnt);
    for (int i = 0; i < idx.size(); i++) begin
      int e;
      e = (r == '1) ? i % N : (i % 2 == 0 ? 0 : 16);
      chk({nm, "_order"}, idx[i], e);
      if (i > 0) chk({nm, "_period"}, t[i] - t[i - 1], PER);
    end
    chk({nm, "_first"}, (t.size() > 0) ? t[0] : -1, 1);
    ch_req = '0;
  endtask

  initial begin
    tbl[0] = '{0, 3, 12'hABC, 1'b0, 18'b00011_101010111100_1};
    tbl[1] = '{0, 3, 12'hABC, 1'b1, 18'b00011_101010111100_1};
    tbl[2] = '{1, 9, 12'h001, 1'b0, 18'b01001_000000000001_1};
    tbl[3] = '{0, 0, 12'h000, 1'b0, 18'b00000_000000000000_0};
    tbl[4] = '{0, 16, 12'hFFF, 1'b0, 18'b10000_111111111111_1};
    tbl[5] = '{0, 2, 12'h001, 1'b0, 18'b00010_000000000001_0};
    tbl[6] = '{1, 7, 12'h0F0, 1'b0, 18'b00111_000011110000_1};
    rec5 = '{0, 5, 12'h800, 1'b0, 18'b00101_100000000000_1};
    rst = 1'b1;
    ch_req = '0;
    ch_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    foreach (tbl[i]) run_single(tbl[i]);
    run_rr("all", '1, 18);
    run_rr("wrap", N'(1) | (N'(1) << 16), 4);
    begin
      int ec;
      do_reset();
      ch_req[7] = 1'b1;
      ch_data[7*12 +: 12] = 12'h0F0;
      ec = 0;
      for (int c = 0; c < 100 && ec < 10; c++) begin
        step();
        if (s_ack0[7]) ch_req[7] = 1'b0;
        if (s_en0) ec++;
      end
      chk("abort_reach", ec, 10);
      rst = 1'b1;
      ch_req[5] = 1'b1;
      ch_data[5*12 +: 12] = 12'h800;
      step();
      chk("abort_inflight", 32'(s_en0), 1);
      rst = 1'b0;
      collect(rec5);
    end
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (ch_req[i] && s_ack0[i]) begin
          if ($urandom_range(1) == 1) ch_req[i] = 1'b0;
          else ch_data[i*12 +: 12] = 12'($urandom);
        end else if (!ch_req[i] && $urandom_range(7) == 0) begin
          ch_req[i] = 1'b1;
          ch_data[i*12 +: 12] = 12'($urandom);
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
